// File: rtl/pkt_buf.sv
// Store-and-forward packet buffer: holds each packet until its keep/discard
// flag arrives, forwards kept packets unchanged and drops discarded ones.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   pktin_data[133:0]      input flit ([133:132] 01 head/11 body/10 tail)
//   pktin_data_wr          input flit strobe
//   pktin_data_valid       packet flag (1 keep, 0 discard)
//   pktin_data_valid_wr    flag strobe, honoured only with a tail flit
//   pktin_data_ready       upstream may start a new packet (registered)
//   pktout_data[133:0]     forwarded flit
//   pktout_data_wr         output flit strobe
//   pktout_data_valid      output flag (always 1 when strobed)
//   pktout_data_valid_wr   output flag strobe, with the output tail flit
//   pktout_data_ready      downstream can absorb one whole packet
//   pkt_drop_cnt[31:0]     overflow-dropped packets, saturating
module pkt_buf #(
  parameter int DATA_AW      = 8,
  parameter int FLAG_AW      = 5,
  parameter int READY_MARGIN = 100
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [133:0] pktin_data,
  input  logic         pktin_data_wr,
  input  logic         pktin_data_valid,
  input  logic         pktin_data_valid_wr,
  output logic         pktin_data_ready,
  output logic [133:0] pktout_data,
  output logic         pktout_data_wr,
  output logic         pktout_data_valid,
  output logic         pktout_data_valid_wr,
  input  logic         pktout_data_ready,
  output logic [31:0]  pkt_drop_cnt
);

  localparam int DDEPTH = 1 << DATA_AW;
  localparam int FDEPTH = 1 << FLAG_AW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DROP
  } state_t;

  logic [133:0] dmem [DDEPTH];
  logic         fmem [FDEPTH];

  logic [DATA_AW:0] wr_q, wr_d;
  logic [DATA_AW:0] commit_q, commit_d;
  logic [DATA_AW:0] rd_q, rd_d;
  logic [FLAG_AW:0] fwr_q, fwr_d;
  logic [FLAG_AW:0] frd_q, frd_d;
  logic             skip_q, skip_d;
  logic [31:0]      drop_q, drop_d;
  logic             ready_q, ready_d;
  state_t           st_q, st_d;
  logic [133:0]     od_q, od_d;
  logic             owr_q, owr_d;
  logic             ov_q, ov_d;

  logic             mem_we;
  logic             flag_push;
  logic             ovf;
  logic             tail_in;
  logic             d_full;
  logic             f_full;
  logic             f_empty;
  logic [DATA_AW:0] d_used;
  logic [FLAG_AW:0] f_used;
  logic [31:0]      d_free;
  logic [31:0]      f_free;
  logic [133:0]     cur_flit;
  logic             cur_tail;
  logic             head_flag;
  logic             pop_flag;

  assign tail_in = pktin_data_wr
                && (pktin_data[133:132] == 2'b10);

  // Full: same index, opposite wrap bit.
  assign d_full = ((wr_q ^ rd_q)
                == {1'b1, {DATA_AW{1'b0}}});
  assign f_full = ((fwr_q ^ frd_q)
                == {1'b1, {FLAG_AW{1'b0}}});
  assign f_empty = (fwr_q == frd_q);

  assign d_used = wr_q - rd_q;
  assign f_used = fwr_q - frd_q;
  assign d_free = 32'(DDEPTH) - 32'(d_used);
  assign f_free = 32'(FDEPTH) - 32'(f_used);

  assign cur_flit  = dmem[rd_q[DATA_AW-1:0]];
  assign cur_tail  = (cur_flit[133:132] == 2'b10);
  assign head_flag = fmem[frd_q[FLAG_AW-1:0]];

  // A discard packet is popped regardless of downstream readiness.
  assign pop_flag = (st_q == S_IDLE) && !f_empty
                 && (!head_flag || pktout_data_ready);

  // Write side: store flits, commit on tail+flag, rewind on overflow.
  always_comb begin
    wr_d      = wr_q;
    commit_d  = commit_q;
    skip_d    = skip_q;
    drop_d    = drop_q;
    mem_we    = 1'b0;
    flag_push = 1'b0;
    ovf       = 1'b0;
    if (pktin_data_wr) begin
      if (skip_q) begin
        if (tail_in) skip_d = 1'b0;
      end else if (d_full
                || (tail_in && pktin_data_valid_wr
                    && f_full)) begin
        ovf    = 1'b1;
        wr_d   = commit_q;
        skip_d = !tail_in;
      end else begin
        mem_we = 1'b1;
        wr_d   = wr_q + 1'b1;
        if (tail_in && pktin_data_valid_wr) begin
          flag_push = 1'b1;
          commit_d  = wr_q + 1'b1;
        end
      end
    end
    if (ovf && (drop_q != 32'hFFFF_FFFF))
      drop_d = drop_q + 32'd1;
  end

  assign fwr_d = fwr_q + {{FLAG_AW{1'b0}}, flag_push};

  assign ready_d = (d_free >= 32'(READY_MARGIN))
                && (f_free >= 32'd2);

  always_ff @(posedge clk) begin
    if (mem_we)
      dmem[wr_q[DATA_AW-1:0]] <= pktin_data;
    if (flag_push)
      fmem[fwr_q[FLAG_AW-1:0]] <= pktin_data_valid;
  end

  // Read FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= S_IDLE;
    else        st_q <= st_d;
  end

  // Read FSM: next state. A committed packet is complete in the
  // data FIFO, so SEND/DROP never wait for flits.
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      S_IDLE: begin
        if (pop_flag)
          st_d = head_flag ? S_SEND : S_DROP;
      end
      S_SEND, S_DROP: begin
        if (cur_tail) st_d = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end

  // Read FSM: outputs and read pointers.
  always_comb begin
    rd_d  = rd_q;
    frd_d = frd_q;
    od_d  = od_q;
    owr_d = 1'b0;
    ov_d  = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        if (pop_flag) frd_d = frd_q + 1'b1;
      end
      S_SEND: begin
        rd_d  = rd_q + 1'b1;
        od_d  = cur_flit;
        owr_d = 1'b1;
        ov_d  = cur_tail;
      end
      S_DROP: begin
        rd_d = rd_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q     <= '0;
      commit_q <= '0;
      rd_q     <= '0;
      fwr_q    <= '0;
      frd_q    <= '0;
      skip_q   <= 1'b0;
      drop_q   <= '0;
      ready_q  <= 1'b0;
      od_q     <= '0;
      owr_q    <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      wr_q     <= wr_d;
      commit_q <= commit_d;
      rd_q     <= rd_d;
      fwr_q    <= fwr_d;
      frd_q    <= frd_d;
      skip_q   <= skip_d;
      drop_q   <= drop_d;
      ready_q  <= ready_d;
      od_q     <= od_d;
      owr_q    <= owr_d;
      ov_q     <= ov_d;
    end
  end

  assign pktin_data_ready     = ready_q;
  assign pktout_data          = od_q;
  assign pktout_data_wr       = owr_q;
  assign pktout_data_valid    = ov_q;
  assign pktout_data_valid_wr = ov_q;
  assign pkt_drop_cnt         = drop_q;

endmodule

// File: tb/tb_pkt_buf.sv
// Scoreboard bench for pkt_buf: default instance plus a small
// instance (DATA_AW=4, READY_MARGIN=4) for overflow.
module tb_pkt_buf;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [133:0] m_data, s_data;
  logic m_wr, m_v, m_vwr, m_ordy;
  logic s_wr, s_v, s_vwr, s_ordy;
  logic m_rdy, m_owr, m_ov, m_ovwr;
  logic s_rdy, s_owr, s_ov, s_ovwr;
  logic [133:0] m_odata, s_odata;
  logic [31:0] m_drop, s_drop;

  pkt_buf u_m (
    .clk                  (clk),
    .rst_n                (rst_n),
    .pktin_data           (m_data),
    .pktin_data_wr        (m_wr),
    .pktin_data_valid     (m_v),
    .pktin_data_valid_wr  (m_vwr),
    .pktin_data_ready     (m_rdy),
    .pktout_data          (m_odata),
    .pktout_data_wr       (m_owr),
    .pktout_data_valid    (m_ov),
    .pktout_data_valid_wr (m_ovwr),
    .pktout_data_ready    (m_ordy),
    .pkt_drop_cnt         (m_drop)
  );

  pkt_buf #(
    .DATA_AW      (4),
    .FLAG_AW      (5),
    .READY_MARGIN (4)
  ) u_s (
    .clk                  (clk),
    .rst_n                (rst_n),
    .pktin_data           (s_data),
    .pktin_data_wr        (s_wr),
    .pktin_data_valid     (s_v),
    .pktin_data_valid_wr  (s_vwr),
    .pktin_data_ready     (s_rdy),
    .pktout_data          (s_odata),
    .pktout_data_wr       (s_owr),
    .pktout_data_valid    (s_ov),
    .pktout_data_valid_wr (s_ovwr),
    .pktout_data_ready    (s_ordy),
    .pkt_drop_cnt         (s_drop)
  );

  typedef struct {
    logic [133:0] d;
    bit           tail;
    int           cyc;
  } exp_t;

  exp_t mq[$];
  exp_t sq[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   m_cnt = 0;
  int   s_cnt = 0;

  function automatic logic [133:0] mk(
    input int n, input int k, input logic [127:0] base);
    logic [127:0] p;
    p = base + 128'(k);
    if (k == 0)          return {2'b01, 4'h0, p};
    else if (k == n - 1) return {2'b10, 4'h4, p};
    else                 return {2'b11, 4'h0, p};
  endfunction

  task automatic chk(input string name,
                     input logic [133:0] act,
                     input logic [133:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input bit sm, input int n,
                          input logic [127:0] base,
                          input int first);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.d    = mk(n, k, base);
      e.tail = (k == n - 1);
      e.cyc  = (first < 0) ? -1 : first + k;
      if (sm) sq.push_back(e);
      else    mq.push_back(e);
    end
  endtask

  task automatic mon(input bit sm, input logic [133:0] d,
                     input logic v, input logic vw);
    exp_t e;
    n_vec++;
    if (sm) s_cnt++;
    else    m_cnt++;
    if ((sm ? sq.size() : mq.size()) == 0) begin
      n_err++;
      $display("FAIL out%0d unexpected flit %h at cyc %0d",
               sm, d, cyc);
    end else begin
      e = sm ? sq.pop_front() : mq.pop_front();
      if (d !== e.d || v !== e.tail || vw !== e.tail
          || (e.cyc >= 0 && cyc != e.cyc)) begin
        n_err++;
        $display("FAIL out%0d flit: got %h v%b/%b cyc %0d want %h v%b cyc %0d",
                 sm, d, v, vw, cyc, e.d, e.tail, e.cyc);
      end
    end
  endtask

  always @(negedge clk)
    if (m_owr === 1'b1) mon(1'b0, m_odata, m_ov, m_ovwr);

  always @(negedge clk)
    if (s_owr === 1'b1) mon(1'b1, s_odata, s_ov, s_ovwr);

  // Drives one flit per clock; caller sits just after a posedge.
  task automatic send_pkt(input bit sm, input int n,
                          input bit keep,
                          input logic [127:0] base);
    for (int k = 0; k < n; k++) begin
      if (sm) begin
        s_data = mk(n, k, base);
        s_wr   = 1'b1;
        s_v    = keep;
        s_vwr  = (k == n - 1);
      end else begin
        m_data = mk(n, k, base);
        m_wr   = 1'b1;
        m_v    = keep;
        m_vwr  = (k == n - 1);
      end
      @(posedge clk);
      #1;
    end
    m_wr = 1'b0; m_vwr = 1'b0; m_v = 1'b0;
    s_wr = 1'b0; s_vwr = 1'b0; s_v = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int t;
  int c0;

  initial begin
    m_data = '0; m_wr = 0; m_v = 0; m_vwr = 0; m_ordy = 1;
    s_data = '0; s_wr = 0; s_v = 0; s_vwr = 0; s_ordy = 1;
    idle(3);
    chk("rst_owr", 134'(m_owr), 134'(0));
    chk("rst_odata", m_odata, 134'(0));
    chk("rst_rdy", 134'(m_rdy), 134'(0));
    chk("rst_drop", 134'(m_drop), 134'(0));
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    chk("rdy_after_rst", 134'(m_rdy), 134'(1));
    chk("s_rdy_after_rst", 134'(s_rdy), 134'(1));
    idle(2);

    // Single keep packet: output from tail+2.
    t = cyc;
    push_exp(1'b0, 6, 128'h1000, t + 8);
    send_pkt(1'b0, 6, 1'b1, 128'h1000);
    idle(12);

    // Single discard packet: nothing out.
    c0 = m_cnt;
    send_pkt(1'b0, 6, 1'b0, 128'h2000);
    idle(10);
    chk("discard_no_out", 134'(m_cnt), 134'(c0));
    chk("discard_rdy", 134'(m_rdy), 134'(1));
    chk("discard_drop", 134'(m_drop), 134'(0));

    // Held by downstream ready, then released.
    m_ordy = 1'b0;
    c0 = m_cnt;
    send_pkt(1'b0, 6, 1'b1, 128'h3000);
    idle(20);
    chk("held_no_out", 134'(m_cnt), 134'(c0));
    t = cyc;
    push_exp(1'b0, 6, 128'h3000, t + 2);
    m_ordy = 1'b1;
    idle(3);
    m_ordy = 1'b0;
    idle(8);
    m_ordy = 1'b1;
    idle(4);

    // Back-to-back keep, discard, keep.
    t = cyc;
    push_exp(1'b0, 6, 128'h4000, t + 8);
    send_pkt(1'b0, 6, 1'b1, 128'h4000);
    send_pkt(1'b0, 6, 1'b0, 128'h5000);
    push_exp(1'b0, 6, 128'h6000, t + 22);
    send_pkt(1'b0, 6, 1'b1, 128'h6000);
    idle(15);
    chk("b2b_drained", 134'(mq.size()), 134'(0));

    // Reset while the third flit is on the output.
    t = cyc;
    push_exp(1'b0, 6, 128'h7000, t + 8);
    send_pkt(1'b0, 6, 1'b1, 128'h7000);
    while (cyc < t + 10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_owr", 134'(m_owr), 134'(0));
    chk("mid_rst_ovwr", 134'(m_ovwr), 134'(0));
    chk("mid_rst_odata", m_odata, 134'(0));
    chk("mid_rst_rdy", 134'(m_rdy), 134'(0));
    mq.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    chk("rdy_after_rst2", 134'(m_rdy), 134'(1));
    t = cyc;
    push_exp(1'b0, 6, 128'h8000, t + 8);
    send_pkt(1'b0, 6, 1'b1, 128'h8000);
    idle(12);

    // Overflow on the 16-deep instance.
    t = cyc;
    send_pkt(1'b1, 20, 1'b1, 128'h9000);
    push_exp(1'b1, 6, 128'hA000, t + 28);
    send_pkt(1'b1, 6, 1'b1, 128'hA000);
    idle(14);
    chk("ovf_drop_cnt", 134'(s_drop), 134'(1));
    chk("ovf_out_cnt", 134'(s_cnt), 134'(6));
    chk("m_drop_end", 134'(m_drop), 134'(0));
    chk("mq_empty", 134'(mq.size()), 134'(0));
    chk("sq_empty", 134'(sq.size()), 134'(0));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pkt_buf.md
# pkt_buf

Store-and-forward packet buffer on each dmux output branch (pgm, lcm and ssm paths). It accepts the 134-bit flit stream with its trailing keep/discard flag, and holds each packet until the flag arrives. Packets flagged keep are forwarded unchanged; packets flagged discard are dropped silently. The block converts dmux's per-packet ready handshake into a downstream per-packet ready handshake.

## Interface
- DATA_AW, 8, log2 of data FIFO depth in flits (256)
- FLAG_AW, 5, log2 of flag FIFO depth in packets (32)
- READY_MARGIN, 100, minimum free data-FIFO words required for pktin_data_ready=1; at least the max packet length in flits
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pktin_data  in  134  flit: [133:132] 01 head, 11 body, 10 tail; [131:128] invalid bytes in tail; [127:0] payload
- pktin_data_wr  in  1  flit write strobe
- pktin_data_valid  in  1  1 keep, 0 discard; meaningful only with pktin_data_valid_wr
- pktin_data_valid_wr  in  1  flag strobe; accepted only in the same cycle as a tail flit write
- pktin_data_ready  out  1  upstream may start a new packet
- pktout_data  out  134  forwarded flit, bit-identical to the input flit
- pktout_data_wr  out  1  output flit strobe
- pktout_data_valid  out  1  always 1 when pktout_data_valid_wr=1
- pktout_data_valid_wr  out  1  flag strobe, coincident with the output tail flit
- pktout_data_ready  in  1  downstream can absorb one whole packet
- pkt_drop_cnt  out  32  overflow-dropped packets, saturating

## Operation
- Data FIFO: 2^DATA_AW x 134. Pointers: wr_ptr, commit_ptr, rd_ptr.
- Flag FIFO: 2^FLAG_AW x 1. One entry is pushed per committed packet.
- Write side:
  - Each pktin_data_wr writes the flit at wr_ptr.
  - When a tail flit and valid_wr arrive together, the flag is pushed and commit_ptr is set to wr_ptr+1.
  - A valid_wr without a tail flit is ignored.
- Overflow (a flit write while the data FIFO is full, or a commit while the flag FIFO is full):
  - wr_ptr rewinds to commit_ptr.
  - All remaining flits of that packet are ignored up to and including its tail.
  - The packet's flag is ignored.
  - pkt_drop_cnt increments once.
- Read FSM:
  - IDLE: if the flag FIFO is non-empty and either (head flag=0) or (head flag=1 and pktout_data_ready=1), pop the flag and go to DROP (flag 0) or SEND (flag 1). Otherwise stay.
  - SEND: pop one flit per cycle, register it to pktout_data and set pktout_data_wr=1. On the tail flit, also set pktout_data_valid=1 and pktout_data_valid_wr=1, then go to IDLE. pktout_data_ready is not re-sampled mid-packet.
  - DROP: pop one flit per cycle with no output. On the tail flit, go to IDLE.
- A committed flag guarantees the whole packet is already in the data FIFO, so SEND and DROP never stall.
- pktin_data_ready is registered. It is 1 iff free words (depth − (wr_ptr − rd_ptr)) ≥ READY_MARGIN and free flag entries ≥ 2. Upstream samples it only before a head flit.
- Pointers are DATA_AW+1 bits with wrap bit. Full means the pointers are equal except the MSB.

## Timing
- Reset values:
  - All outputs 0, except pktin_data_ready, which goes to 1 one cycle after reset release.
  - FSM in IDLE.
  - All pointers 0.
  - pkt_drop_cnt 0.
- Latency: tail flit with valid_wr sampled at edge N → flag FIFO non-empty after N → FSM enters SEND at edge N+1 → first pktout_data_wr high after edge N+2.
- An n-flit packet is output on n consecutive cycles.
- There is one IDLE cycle between consecutive SEND/DROP packets.
- Simultaneous push and pop on either FIFO is legal. Occupancy is unchanged and the flags are computed from the post-update pointers.
- Reset mid-packet: all state is cleared immediately (asynchronously). Partial input packets are lost, and the output strobes drop to 0 at once.
- pkt_drop_cnt holds at 0xFFFFFFFF.

## Test plan
- One 6-flit packet (head {6'b010000,...}, bodies, tail {6'b100000,128'd4}, valid=1), pktout_data_ready=1:
  - Six identical flits appear starting 2 cycles after the tail.
  - valid/valid_wr are 1 only with flit 6.
- Same packet with valid=0:
  - No pktout_data_wr.
  - After ~8 cycles the FIFOs are empty and pktin_data_ready=1.
  - pkt_drop_cnt=0.
- Keep-packet stored with pktout_data_ready=0 for 20 cycles:
  - No output during those cycles.
  - Raising ready → all 6 flits stream 2 cycles later.
  - Lowering ready mid-packet does not interrupt the stream.
- Three back-to-back packets (keep, discard, keep), each 6 flits:
  - Output is packet 1, then packet 3.
  - Exactly one idle cycle separates the SEND/DROP/SEND phases.
- Overflow, with DATA_AW=4 and READY_MARGIN=4: send a 20-flit keep packet ignoring ready, then a 6-flit keep packet.
  - Only the 6-flit packet is output.
  - pkt_drop_cnt=1.
- Assert rst_n=0 during SEND of flit 3:
  - Outputs go to 0 immediately.
  - After release, a new 6-flit packet passes unchanged.
